local_bias_seq: RTL
===================

Name: local_bias_seq

Overview:
- Synchronous power-up sequencer and self-test controller for the local bias generator; it is the initiator side of the generator's pdb/atb_ena interface.
- Drives pdb and atb_ena, qualifies the analog supplies, and steps the analog testbus through every mode.
- Checks the returned atb1/atb0 levels against limits, then declares bias ready or latches a coded fault.
- Sits in the digital control island next to each local bias instance; RNM real ports are used for analog observation.

Parameters:
SUP_STABLE_CYC, 16, consecutive in-range supply samples required before enabling bias
SUP_TIMEOUT_CYC, 1000, max cycles in PWR_CHK before supply fault
SETTLE_CYC, 64, cycles after pdb rise before first testbus access
ATB_SETTLE_CYC, 8, cycles after each atb_ena change before sampling
V_TOL, 0.05, relative voltage tolerance (±5%)
I_TOL, 0.10, relative current tolerance (±10%)

Ports:
clk  input  1  sequencer clock
rstb  input  1  asynchronous active-low reset
start  input  1  level request: high = bring up bias, low = power down/abort
vddana_1p8  input  real  1.8 V supply observation
vddana_0p8  input  real  0.8 V supply observation
atb1  input  real  analog testbus 1 from bias block
atb0  input  real  analog testbus 0 from bias block
pdb  output  1  bias power-down-bar to bias block
atb_ena  output  [0:1]  testbus mode select to bias block
busy  output  1  sequence in progress
ready  output  1  bias up and self-test passed
fault  output  1  fault latched
fault_code  output  3  0 none, 1 supply timeout, 2 ATB 1p8 fail, 3 ATB 0p8 fail, 4 ATB current fail, 5 supply loss in READY

Behaviour:
- Reset (rstb=0, async): state IDLE, pdb=0, atb_ena=00, busy=0, ready=0, fault=0, fault_code=0, all counters 0. Outputs are registered; they change only on clk rising edge after reset release.
- Range checks are combinational on real inputs and sampled at clk rising edge; bounds are inclusive: ref*(1-tol) <= x <= ref*(1+tol).
- Any Z/NaN real value fails every comparison and is therefore out of range.
- One 16-bit counter is shared by all states; it clears on every state transition.
- IDLE: pdb=0, atb_ena=00. If start=1 -> PWR_CHK, busy=1.
- PWR_CHK: pdb=0. While both supplies are in range, the stable count increments; any out-of-range sample clears it. When the stable count reaches SUP_STABLE_CYC -> ENABLE. If total cycles in state reach SUP_TIMEOUT_CYC first -> FAULT, code 1. If both occur on the same cycle, stable wins.
- ENABLE: pdb=1. After SETTLE_CYC cycles -> ATB_1P8.
- ATB_1P8: atb_ena=01. On cycle ATB_SETTLE_CYC, sample once; atb1 and atb0 must both be within 1.8 V ±V_TOL. Pass -> ATB_0P8; fail -> FAULT, code 2.
- ATB_0P8: atb_ena=10. Same timing; both must be within 0.8 V ±V_TOL. Pass -> ATB_CUR; fail -> FAULT, code 3.
- ATB_CUR: atb_ena=11. Same timing; atb1 must be within 25e-6 ±I_TOL and atb0 within 500e-6 ±I_TOL. Pass -> READY; fail -> FAULT, code 4.
- READY: atb_ena=00, pdb=1, ready=1, busy=0. Supplies are monitored every cycle; a single out-of-range sample -> FAULT, code 5.
- FAULT: pdb=0, atb_ena=00, fault=1, ready=0, busy=0. fault_code holds its value. Only start=0 clears the fault: -> IDLE, fault and code cleared. Holding start=1 does not retry.
- start=0 in any non-FAULT state: -> IDLE next cycle, pdb=0, atb_ena=00, ready=0, no fault.
- If start falls on the same cycle as a check failure, abort wins: -> IDLE with no fault.
- atb_ena changes only on state entry, never mid-settle.
- Nominal bring-up latency from start=1 to ready=1 is 1 + SUP_STABLE_CYC + SETTLE_CYC + 3*ATB_SETTLE_CYC cycles (105 with defaults), assuming clean supplies.
- Reset mid-sequence: immediate async return to reset values, including pdb=0.

Test Plan:
- Nominal: supplies 1.8/0.8 V, bias model ideal, start=1 -> pdb rises cycle 17; atb_ena steps 01->10->11->00; ready=1 at cycle 105; fault=0.
- Supply never valid: vddana_0p8=0.70 V, start=1 -> pdb stays 0; FAULT at cycle 1001, fault_code=1; start=0 -> IDLE, fault=0.
- Boundary: vddana_1p8=1.71 V (exactly -5%) passes; 1.7099 V keeps PWR_CHK resetting stable count -> timeout code 1.
- ATB current fail: force atb0=440e-6 in mode 11 -> fault_code=4, pdb=0, atb_ena=00.
- Supply loss in READY: after ready=1, drop vddana_1p8 to 1.6 V for one cycle -> next edge fault=1, code 5, pdb=0, ready=0.
- Abort/reset: start=0 during ATB_0P8 -> IDLE next cycle, no fault. Separately, rstb=0 mid-ENABLE -> pdb=0 immediately without a clk edge.

Source files
------------

// File: rtl/local_bias_seq.sv
// Power-up sequencer and testbus self-test for one local bias generator.
// It qualifies the supplies, enables the bias, steps atb_ena through all modes, then reports ready or a fault code.
module local_bias_seq #(
  parameter int unsigned SUP_STABLE_CYC  = 16,
  parameter int unsigned SUP_TIMEOUT_CYC = 1000,
  parameter int unsigned SETTLE_CYC      = 64,
  parameter int unsigned ATB_SETTLE_CYC  = 8,
  parameter real         V_TOL           = 0.05,
  parameter real         I_TOL           = 0.10
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  input  real        vddana_1p8,
  input  real        vddana_0p8,
  input  real        atb1,
  input  real        atb0,
  output logic       pdb,
  output logic [0:1] atb_ena,
  output logic       busy,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CODE_W = 3;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(SUP_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SUP_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ATB_LAST     = CNT_W'(ATB_SETTLE_CYC - 1);

  localparam logic [CODE_W-1:0] CODE_NONE    = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_SUP_TO  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_ATB_1P8 = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_ATB_0P8 = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_ATB_CUR = CODE_W'(4);
  localparam logic [CODE_W-1:0] CODE_SUP_LOS = CODE_W'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_CHK, S_ENABLE, S_ATB_1P8, S_ATB_0P8, S_ATB_CUR, S_READY, S_FAULT
  } state_e;

  // Inclusive window; NaN fails both compares so it reads as out of range.
  function automatic logic in_rng(input real x, input real nom, input real tol);
    return (x >= nom * (1.0 - tol)) && (x <= nom * (1.0 + tol));
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    stab_q, stab_d;
  logic [CODE_W-1:0]   fault_code_q, fault_code_d;
  logic                pdb_q, pdb_d;
  logic [0:1]          atb_ena_q, atb_ena_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  logic sup_ok, atb_1p8_ok, atb_0p8_ok, atb_cur_ok;

  always_comb begin
    sup_ok     = in_rng(vddana_1p8, 1.8, V_TOL) && in_rng(vddana_0p8, 0.8, V_TOL);
    atb_1p8_ok = in_rng(atb1, 1.8, V_TOL) && in_rng(atb0, 1.8, V_TOL);
    atb_0p8_ok = in_rng(atb1, 0.8, V_TOL) && in_rng(atb0, 0.8, V_TOL);
    atb_cur_ok = in_rng(atb1, 25.0e-6, I_TOL) && in_rng(atb0, 500.0e-6, I_TOL);
  end

  // Next state, shared counter and fault code.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    stab_d       = '0;
    fault_code_d = fault_code_q;

    unique case (state_q)
      S_IDLE: begin
        fault_code_d = CODE_NONE;
        if (start) state_d = S_PWR_CHK;
      end
      S_PWR_CHK: begin
        stab_d = sup_ok ? stab_q + CNT_W'(1) : '0;
        // Stability is checked first so it wins a tie with the timeout.
        if (sup_ok && stab_q == STABLE_LAST) begin
          state_d = S_ENABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = CODE_SUP_TO;
        end
      end
      S_ENABLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_ATB_1P8;
      end
      S_ATB_1P8: begin
        if (cnt_q == ATB_LAST) begin
          if (atb_1p8_ok) begin
            state_d = S_ATB_0P8;
          end else begin
            state_d      = S_FAULT;
            fault_code_d = CODE_ATB_1P8;
          end
        end
      end
      S_ATB_0P8: begin
        if (cnt_q == ATB_LAST) begin
          if (atb_0p8_ok) begin
            state_d = S_ATB_CUR;
          end else begin
            state_d      = S_FAULT;
            fault_code_d = CODE_ATB_0P8;
          end
        end
      end
      S_ATB_CUR: begin
        if (cnt_q == ATB_LAST) begin
          if (atb_cur_ok) begin
            state_d = S_READY;
          end else begin
            state_d      = S_FAULT;
            fault_code_d = CODE_ATB_CUR;
          end
        end
      end
      S_READY: begin
        if (!sup_ok) begin
          state_d      = S_FAULT;
          fault_code_d = CODE_SUP_LOS;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping start aborts any sequence and clears a latched fault.
    if (!start) begin
      state_d      = S_IDLE;
      fault_code_d = CODE_NONE;
    end

    if (state_d != state_q) begin
      cnt_d  = '0;
      stab_d = '0;
    end
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    pdb_d     = 1'b0;
    atb_ena_d = 2'b00;
    busy_d    = 1'b0;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_d)
      S_PWR_CHK: busy_d = 1'b1;
      S_ENABLE: begin
        pdb_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_ATB_1P8: begin
        pdb_d     = 1'b1;
        busy_d    = 1'b1;
        atb_ena_d = 2'b01;
      end
      S_ATB_0P8: begin
        pdb_d     = 1'b1;
        busy_d    = 1'b1;
        atb_ena_d = 2'b10;
      end
      S_ATB_CUR: begin
        pdb_d     = 1'b1;
        busy_d    = 1'b1;
        atb_ena_d = 2'b11;
      end
      S_READY: begin
        pdb_d   = 1'b1;
        ready_d = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      stab_q       <= '0;
      fault_code_q <= CODE_NONE;
      pdb_q        <= 1'b0;
      atb_ena_q    <= 2'b00;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      fault_code_q <= fault_code_d;
      pdb_q        <= pdb_d;
      atb_ena_q    <= atb_ena_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pdb        = pdb_q;
  assign atb_ena    = atb_ena_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
